fpadd_arb: RTL and testbench
============================

FPADD_ARB -- requirements
Module: fpadd_arb

Interface
REQ-001 The block SHALL have parameter LATENCY, default 4, meaning cycles from the fa_start pulse to a valid fa_s (legal range 1..15).
REQ-002 Port clk, input, 1 bit: the single clock; all state SHALL update on the rising edge.
REQ-003 Port clr, input, 1 bit: asynchronous, active-low reset.
REQ-004 Port req0, input, 1 bit: requester 0 operation request, level.
REQ-005 Ports a0 and b0, input, 8 bits each: requester 0 operands.
REQ-006 Port req1, input, 1 bit: requester 1 operation request, level.
REQ-007 Ports a1 and b1, input, 8 bits each: requester 1 operands.
REQ-008 Ports fa_a and fa_b, output, 8 bits each: registered operands to the shared fpadd.
REQ-009 Port fa_start, output, 1 bit: one-cycle start pulse to fpadd.
REQ-010 Port fa_s, input, 8 bits: fpadd sum.
REQ-011 Port result, output, 8 bits: registered sum of the last completed operation.
REQ-012 Ports done0 and done1, output, 1 bit each: one-cycle completion pulse to the owning requester.
REQ-013 Port busy, output, 1 bit: high in every state except IDLE.
REQ-014 Port op_count, output, 8 bits: completed-operation counter (see Configuration).

Function
REQ-015 The FSM SHALL have four states: IDLE, ISSUE, WAIT and DONE.
REQ-016 In IDLE, when any req is high, the arbiter SHALL grant one requester, latch that requester's a/b into fa_a/fa_b, record the owner and move to ISSUE; with no req it SHALL stay in IDLE.
REQ-017 Arbitration SHALL be round-robin: if both reqs are high, grant the requester not served last; a lone request is granted regardless of the pointer.
REQ-018 The pointer SHALL update only on grant.
REQ-019 In ISSUE, fa_start SHALL be 1 for exactly one cycle, the wait counter SHALL load LATENCY, and the FSM SHALL move to WAIT.
REQ-020 In WAIT, the counter SHALL decrement each cycle; when it reaches 1, result SHALL capture fa_s and the FSM SHALL move to DONE.
REQ-021 In DONE, the owner's done SHALL be 1 for one cycle, the other done SHALL stay 0, and the FSM SHALL move to IDLE.
REQ-022 Latency: if req is first sampled in IDLE at cycle 0, fa_start SHALL be high in cycle 1 and done SHALL be high in cycle LATENCY+2.
REQ-023 fa_a and fa_b SHALL hold steady from grant until the FSM returns to IDLE; operand changes on a/b after grant SHALL be ignored.
REQ-024 If the owner drops req after grant, the operation SHALL still complete and pulse done.
REQ-025 The losing requester's req SHALL remain pending with no done pulse until it is granted.
REQ-026 A req still high in the IDLE cycle after DONE SHALL be treated as a new request.
REQ-027 result SHALL hold its value until the next capture.
REQ-028 fa_start, done0 and done1 SHALL be 0 in all states not named above.

Reset
REQ-029 While clr=0, the block SHALL force: state IDLE, fa_a=0, fa_b=0, fa_start=0, result=0, done0=0, done1=0, busy=0, op_count=0, pointer favouring requester 0.
REQ-030 Reset asserted mid-operation SHALL abort the operation with no done pulse.
REQ-031 After clr deasserts, the first IDLE cycle SHALL arbitrate normally.

Configuration
REQ-032 Macro FPADD_ARB_OPCOUNT_EN: when defined, op_count SHALL increment by 1 in each DONE cycle and saturate at 0xFF.
REQ-033 Without FPADD_ARB_OPCOUNT_EN, op_count SHALL be constant 0 and no counter register SHALL exist.

Verification
REQ-034 Bench stub fpadd returns (a+b) mod 256 LATENCY cycles after start. Single request: req0=1, a0=0x12, b0=0x34 -> fa_start in cycle 1, done0 in cycle 6, result=0x46, done1 never high.
REQ-035 Contention after reset: req0 and req1 both high with a1=0x01, b1=0x02 -> requester 0 served first, requester 1 served second (done1, result=0x03), no gap beyond one IDLE cycle between operations.
REQ-036 Fairness: both reqs held high for 6 operations -> grants alternate 0,1,0,1,0,1.
REQ-037 Mid-operation: requester 0 drops req0 in WAIT and changes a0 to 0xFF -> done0 still pulses and result reflects the latched operands.
REQ-038 Reset in WAIT: clr=0 for 2 cycles -> all outputs 0, no done pulse, IDLE afterwards.
REQ-039 With FPADD_ARB_OPCOUNT_EN defined, run 260 operations -> op_count=0xFF; without the macro, op_count=0 throughout.

Source files
------------

// File: rtl/fpadd_arb.sv
// rtl/fpadd_arb.sv - round-robin arbiter sharing one fixed-latency fpadd between two requesters
// Optional feature: define FPADD_ARB_OPCOUNT_EN to enable the saturating completed-operation counter.
module fpadd_arb #(
  parameter int LATENCY = 4
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       req0,
  input  logic [7:0] a0,
  input  logic [7:0] b0,
  input  logic       req1,
  input  logic [7:0] a1,
  input  logic [7:0] b1,
  output logic [7:0] fa_a,
  output logic [7:0] fa_b,
  output logic       fa_start,
  input  logic [7:0] fa_s,
  output logic [7:0] result,
  output logic       done0,
  output logic       done1,
  output logic       busy,
  output logic [7:0] op_count
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [3:0] LAT = LATENCY[3:0];

  state_t     state;
  state_t     state_nxt;
  logic       owner;
  logic       last;
  logic [3:0] cnt;
  logic       grant_any;
  logic       grant_sel;

  // Round-robin choice: a lone request wins outright, a tie goes to whoever was not served last.
  always_comb begin
    grant_any = req0 | req1;
    grant_sel = (req0 & req1) ? ~last : req1;
  end

  // Next-state and Moore outputs; pulses are decoded from the state so they last exactly one cycle.
  always_comb begin
    state_nxt = state;
    fa_start  = 1'b0;
    done0     = 1'b0;
    done1     = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE:  if (grant_any) state_nxt = ISSUE;
      ISSUE: begin
        fa_start  = 1'b1;
        state_nxt = WAIT;
      end
      WAIT:  if (cnt == 4'd1) state_nxt = DONE;
      DONE:  begin
        done0     = ~owner;
        done1     = owner;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state <= IDLE;
    else      state <= state_nxt;
  end

  // Grant capture, latency countdown and result capture; the pointer resets to favour requester 0.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      fa_a   <= 8'h00;
      fa_b   <= 8'h00;
      owner  <= 1'b0;
      last   <= 1'b1;
      cnt    <= 4'd0;
      result <= 8'h00;
    end else begin
      case (state)
        IDLE: if (grant_any) begin
          fa_a  <= grant_sel ? a1 : a0;
          fa_b  <= grant_sel ? b1 : b0;
          owner <= grant_sel;
          last  <= grant_sel;
        end
        ISSUE: cnt <= LAT;
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) result <= fa_s;
        end
        default: ;
      endcase
    end
  end

`ifdef FPADD_ARB_OPCOUNT_EN
  // Count completed operations, sticking at 0xFF.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr)                                      op_count <= 8'h00;
    else if (state == DONE && op_count != 8'hFF)   op_count <= op_count + 8'd1;
  end
`else
  assign op_count = 8'h00;
`endif

endmodule

// File: tb/tb_fpadd_arb.sv
// tb/tb_fpadd_arb.sv - self-checking bench for fpadd_arb with a stub fixed-latency adder
module tb_fpadd_arb;

  localparam int LAT = 4;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [7:0] a0 = 8'h00, b0 = 8'h00, a1 = 8'h00, b1 = 8'h00;
  logic [7:0] fa_a, fa_b, fa_s, result, op_count;
  logic       fa_start, done0, done1, busy;

  int n_chk = 0;
  int n_fail = 0;
  int ops = 0;
  int done_seen = 0;
  logic m_last = 1'b1;

  int stub_cnt = 0;
  logic [7:0] stub_sum = 8'h00;

  fpadd_arb #(.LATENCY(LAT)) dut (
    .clk(clk), .clr(clr),
    .req0(req0), .a0(a0), .b0(b0),
    .req1(req1), .a1(a1), .b1(b1),
    .fa_a(fa_a), .fa_b(fa_b), .fa_start(fa_start), .fa_s(fa_s),
    .result(result), .done0(done0), .done1(done1), .busy(busy),
    .op_count(op_count)
  );

  always #5 clk = ~clk;

  // Stub adder: sum is presented only in the cycle LAT cycles after the start pulse.
  always @(posedge clk) begin
    if (fa_start) begin
      stub_cnt <= LAT;
      stub_sum <= fa_a + fa_b;
    end else if (stub_cnt != 0) begin
      stub_cnt <= stub_cnt - 1;
    end
    if (done0 | done1) done_seen <= done_seen + 1;
  end
  assign fa_s = (stub_cnt == 1) ? stub_sum : 8'hEE;

  typedef struct {
    logic       r0;
    logic [7:0] x0, y0;
    logic       r1;
    logic [7:0] x1, y1;
    logic       pert;
    logic       own;
    logic [7:0] res;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_count();
`ifdef FPADD_ARB_OPCOUNT_EN
    return (ops > 255) ? 32'd255 : 32'(ops);
`else
    return 32'd0;
`endif
  endfunction

  // Called at a negedge with the DUT in IDLE; runs one operation to completion.
  task automatic do_op(input logic r0, input logic [7:0] x0, input logic [7:0] y0,
                       input logic r1, input logic [7:0] x1, input logic [7:0] y1,
                       input logic pert, input logic eown, input logic [7:0] eres);
    int cyc;
    int starts;
    bit got;
    bit opnd_bad;
    logic [7:0] ea, eb;
    chk("idle_busy", 32'(busy), 32'd0);
    req0 = r0; a0 = x0; b0 = y0;
    req1 = r1; a1 = x1; b1 = y1;
    ea = eown ? x1 : x0;
    eb = eown ? y1 : y0;
    cyc = 0; starts = 0; got = 0; opnd_bad = 0;
    while (!got && cyc < LAT + 20) begin
      @(negedge clk);
      cyc++;
      if (fa_start) starts++;
      if (fa_a !== ea || fa_b !== eb) opnd_bad = 1;
      if (cyc == 1) chk("start_cycle", 32'(fa_start), 32'd1);
      if (pert && cyc == 2) begin
        if (eown) begin req1 = 1'b0; a1 = 8'hFF; end
        else      begin req0 = 1'b0; a0 = 8'hFF; end
      end
      if (done0 | done1) got = 1;
    end
    chk("done_seen", 32'(got), 32'd1);
    chk("done_cycle", 32'(cyc), 32'(LAT + 2));
    chk("done_owner", 32'({done1, done0}), eown ? 32'd2 : 32'd1);
    chk("result", 32'(result), 32'(eres));
    chk("start_pulses", 32'(starts), 32'd1);
    chk("operands_held", 32'(opnd_bad), 32'd0);
    m_last = eown;
    ops++;
    @(negedge clk);
    chk("op_count", 32'(op_count), exp_count());
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_fa_a"}, 32'(fa_a), 32'd0);
    chk({tag, "_fa_b"}, 32'(fa_b), 32'd0);
    chk({tag, "_fa_start"}, 32'(fa_start), 32'd0);
    chk({tag, "_result"}, 32'(result), 32'd0);
    chk({tag, "_done"}, 32'({done1, done0}), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_op_count"}, 32'(op_count), 32'd0);
  endtask

  initial begin
    int snap;
    logic r0, r1, own, pert;
    logic [7:0] x0, y0, x1, y1, res;

    tbl[0]  = '{1'b1, 8'h10, 8'h20, 1'b1, 8'h01, 8'h02, 1'b0, 1'b0, 8'h30};
    tbl[1]  = '{1'b1, 8'h10, 8'h20, 1'b1, 8'h01, 8'h02, 1'b0, 1'b1, 8'h03};
    tbl[2]  = '{1'b1, 8'h12, 8'h34, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h46};
    tbl[3]  = '{1'b0, 8'h00, 8'h00, 1'b1, 8'h80, 8'h90, 1'b0, 1'b1, 8'h10};
    tbl[4]  = '{1'b1, 8'h05, 8'h06, 1'b1, 8'h07, 8'h08, 1'b0, 1'b0, 8'h0B};
    tbl[5]  = '{1'b1, 8'h05, 8'h06, 1'b1, 8'h07, 8'h08, 1'b0, 1'b1, 8'h0F};
    tbl[6]  = '{1'b1, 8'h05, 8'h06, 1'b1, 8'h07, 8'h08, 1'b0, 1'b0, 8'h0B};
    tbl[7]  = '{1'b1, 8'h05, 8'h06, 1'b1, 8'h07, 8'h08, 1'b0, 1'b1, 8'h0F};
    tbl[8]  = '{1'b1, 8'h05, 8'h06, 1'b1, 8'h07, 8'h08, 1'b0, 1'b0, 8'h0B};
    tbl[9]  = '{1'b1, 8'h05, 8'h06, 1'b1, 8'h07, 8'h08, 1'b0, 1'b1, 8'h0F};
    tbl[10] = '{1'b1, 8'h40, 8'h01, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h41};
    tbl[11] = '{1'b1, 8'hFF, 8'h01, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00};

    #2 clr = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    clr = 1'b1;
    m_last = 1'b1;
    ops = 0;

    for (int i = 0; i < 12; i++)
      do_op(tbl[i].r0, tbl[i].x0, tbl[i].y0, tbl[i].r1, tbl[i].x1, tbl[i].y1,
            tbl[i].pert, tbl[i].own, tbl[i].res);

    // Abort an operation in WAIT with a two-cycle reset.
    req0 = 1'b1; a0 = 8'h03; b0 = 8'h04; req1 = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd1);
    snap = done_seen;
    clr = 1'b0;
    req0 = 1'b0;
    #1;
    chk_reset_outputs("abort");
    repeat (2) @(negedge clk);
    clr = 1'b1;
    repeat (LAT + 4) @(negedge clk);
    chk("abort_no_done", 32'(done_seen - snap), 32'd0);
    chk_reset_outputs("after_abort");
    m_last = 1'b1;
    ops = 0;

    do_op(tbl[0].r0, tbl[0].x0, tbl[0].y0, tbl[0].r1, tbl[0].x1, tbl[0].y1, 1'b0, tbl[0].own, tbl[0].res);
    do_op(tbl[1].r0, tbl[1].x0, tbl[1].y0, tbl[1].r1, tbl[1].x1, tbl[1].y1, 1'b0, tbl[1].own, tbl[1].res);

    // Random operations against the round-robin model.
    for (int i = 0; i < 260; i++) begin
      r0 = 1'($urandom_range(0, 1));
      r1 = 1'($urandom_range(0, 1));
      if (!r0 && !r1) r0 = 1'b1;
      x0 = 8'($urandom); y0 = 8'($urandom);
      x1 = 8'($urandom); y1 = 8'($urandom);
      pert = ($urandom_range(0, 3) == 0);
      own = (r0 && r1) ? ~m_last : r1;
      res = own ? (x1 + y1) : (x0 + y0);
      do_op(r0, x0, y0, r1, x1, y1, pert, own, res);
    end

    req0 = 1'b0; req1 = 1'b0;
    repeat (3) @(negedge clk);
    chk("final_idle", 32'(busy), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
